// File: rtl/multicycle_add_sub_pkg.sv
// ============================================================================
// Module  : multicycle_add_sub_pkg
// Brief   : Shared state encoding, counter sizing and saturation limits.
// Revision: 1.0
// ============================================================================
`default_nettype none

package multicycle_add_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

    // Limits are produced at up to 64 bits and truncated by the user.
    function automatic logic [63:0] sat_pos(input int width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_neg(input int width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_add_sub_add_chunk.sv
// ============================================================================
// Module  : add_chunk
// Brief   : CHUNK-bit ripple of full-adder cells, purely combinational.
// Revision: 1.0
// ============================================================================
`default_nettype none

module add_chunk #(
    parameter int CHUNK = 1
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);

    always_comb begin
        logic carry;
        carry    = cin;
        c_msb_in = cin;
        s        = '0;
        for (int i = 0; i < CHUNK; i++) begin
            c_msb_in = carry;
            s[i]     = a[i] ^ b[i] ^ carry;
            carry    = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_add_sub.sv
// ============================================================================
// Module  : multicycle_add_sub
// Brief   : Multi-cycle add/sub, CHUNK bits per clock, valid/ready on both sides.
//           Optional saturation: define MULTICYCLE_ADD_SUB_SATURATE_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module multicycle_add_sub
    import multicycle_add_sub_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CHUNK = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int c_n_chunks = WIDTH / CHUNK;
    localparam int c_cnt_w    = clog2(c_n_chunks + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(c_n_chunks);

    if (WIDTH < 2) begin : g_bad_width
        $error("multicycle_add_sub: WIDTH must be >= 2");
    end
    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
        $error("multicycle_add_sub: WIDTH must be a multiple of CHUNK");
    end

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
    logic               carry_q, carry_d, cmsb_q, cmsb_d;
    logic               cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;

    logic [CHUNK-1:0]   w_chunk_s;
    logic               w_chunk_cout;
    logic               w_chunk_cmsb;
    logic               w_ovf;
    logic [WIDTH-1:0]   w_final;

    add_chunk #(.CHUNK(CHUNK)) u_add_chunk (
        .a        (a_q[CHUNK-1:0]),
        .b        (b_q[CHUNK-1:0]),
        .cin      (carry_q),
        .s        (w_chunk_s),
        .cout     (w_chunk_cout),
        .c_msb_in (w_chunk_cmsb)
    );

    assign w_ovf = carry_q ^ cmsb_q;

`ifdef MULTICYCLE_ADD_SUB_SATURATE_EN
    localparam logic [WIDTH-1:0] c_sat_pos = WIDTH'(sat_pos(WIDTH));
    localparam logic [WIDTH-1:0] c_sat_neg = WIDTH'(sat_neg(WIDTH));
    // On overflow the wrapped MSB is the inverse of the common operand sign.
    assign w_final = w_ovf ? (res_q[WIDTH-1] ? c_sat_pos : c_sat_neg) : res_q;
`else
    assign w_final = res_q;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cmsb_d  = cmsb_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q == c_cnt_last) begin
                    // All chunks done; register the flags from the full result.
                    sum_d   = w_final;
                    cout_d  = carry_q;
                    ovf_d   = w_ovf;
                    zero_d  = (w_final == '0);
                    state_d = DONE;
                end else begin
                    res_d   = (res_q >> CHUNK) | (WIDTH'(w_chunk_s) << (WIDTH - CHUNK));
                    a_d     = a_q >> CHUNK;
                    b_d     = b_q >> CHUNK;
                    carry_d = w_chunk_cout;
                    cmsb_d  = w_chunk_cmsb;
                    cnt_d   = cnt_q + c_cnt_w'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cmsb_q  <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cmsb_q  <= cmsb_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

`default_nettype wire
